// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped UART transmitter with a 4-entry byte FIFO and status register.
module mmio_uart_tx #(
  parameter int          CLKS_PER_BIT = 16,
  parameter logic [31:0] TX_ADDR      = 32'h0000_0400,
  parameter logic [31:0] STAT_ADDR    = 32'h0000_0404
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic        ByteMem,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        tx,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t      state, next_state;
  logic [7:0]  mem [4];
  logic [1:0]  wp, rp;
  logic [2:0]  count, bit_cnt;
  logic [9:0]  baud;
  logic [7:0]  shreg, next_shreg;
  logic        ovf, tx_next, push, pop, full, accept, drop, clr, bit_end;
  logic        unused_bits;
  // Byte and word stores both push the low byte, so width and upper data bits are don't-care.
  assign unused_bits = ^{ByteMem, WriteData[31:8]};
  assign push    = MemWrite && DataAdr == TX_ADDR;
  assign clr     = MemWrite && DataAdr == STAT_ADDR && WriteData[0];
  assign pop     = state == IDLE && count != 3'd0;
  assign full    = count == 3'd4;
  assign accept  = push && (!full || pop);
  assign drop    = push && full && !pop;
  assign bit_end = baud == 10'(CLKS_PER_BIT - 1);
  assign busy    = state != IDLE || count != 3'd0;
  assign ReadData = DataAdr == STAT_ADDR ? {25'd0, count, ovf, busy, count == 3'd0, full} : 32'd0;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= next_state;
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (count != 3'd0) next_state = START;
      START:   if (bit_end) next_state = DATA;
      DATA:    if (bit_end && bit_cnt == 3'd7) next_state = STOP;
      STOP:    if (bit_end) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end
  // tx is registered from the next state so the line changes on the same edge as the FSM.
  always_comb begin
    next_shreg = pop ? mem[rp] : (state == DATA && bit_end) ? shreg >> 1 : shreg;
    tx_next    = next_state == START ? 1'b0 : next_state == DATA ? next_shreg[0] : 1'b1;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      tx      <= 1'b1;
      shreg   <= 8'd0;
      baud    <= 10'd0;
      bit_cnt <= 3'd0;
      wp      <= 2'd0;
      rp      <= 2'd0;
      count   <= 3'd0;
      ovf     <= 1'b0;
    end else begin
      tx      <= tx_next;
      shreg   <= next_shreg;
      baud    <= (state == IDLE || bit_end) ? 10'd0 : baud + 10'd1;
      bit_cnt <= state != DATA ? 3'd0 : bit_end ? bit_cnt + 3'd1 : bit_cnt;
      wp      <= wp + 2'(accept);
      rp      <= rp + 2'(pop);
      count   <= count + 3'(accept) - 3'(pop);
      ovf     <= drop ? 1'b1 : clr ? 1'b0 : ovf;
    end
  always_ff @(posedge clk)
    if (accept) mem[wp] <= WriteData[7:0];
endmodule
